bank_access_arbiter: RTL and testbench
======================================

Name: bank_access_arbiter

Overview:
- Shares the single-port APB data bank between two requesters:
  - the CPU-side APB access path, which reads and writes;
  - the watermark block-fetch engine, which only reads.
- Fixed CPU priority, with an anti-starvation override for the engine.
- Tags each issued read with its owner and routes the bank read data back to the correct requester with a valid strobe.
- Sits between the top-level watermark controller and the data bank, replacing direct bank drive from the controller.

Parameters:
- AMBA_WORD, 16, data width of the bank words.
- ADDR_W, 21, bank address width (address depth 20 + 1).
- MAX_WAIT, 4, consecutive engine stall cycles before the engine wins priority (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cpu_req  in  1  CPU access request; held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  AMBA_WORD  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  AMBA_WORD  CPU read data
- eng_en  in  1  engine allowed to access the bank (start && !Image_Done)
- eng_req  in  1  engine read request; held until granted
- eng_addr  in  ADDR_W  engine read address
- eng_gnt  out  1  engine request accepted this cycle
- eng_rvalid  out  1  eng_rdata valid
- eng_rdata  out  AMBA_WORD  engine read data (pixel word)
- bank_we  out  1  bank write enable
- bank_addr  out  ADDR_W  bank address
- bank_wdata  out  AMBA_WORD  bank write data
- bank_rdata  in  AMBA_WORD  bank read data; valid one cycle after address is registered
- eng_stall_cnt  out  4  current engine wait count (debug)

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. All registered outputs clear to 0:
  - bank_we=0, bank_addr=0, bank_wdata=0;
  - cpu_rvalid=0, eng_rvalid=0;
  - wait_cnt=0, pipeline tags cleared.
- Grant logic is combinational from current requests and wait_cnt:
  - eng_ok = eng_req && eng_en.
  - If wait_cnt == MAX_WAIT and eng_ok: eng_gnt=1, cpu_gnt=0.
  - Else if cpu_req: cpu_gnt=1, eng_gnt=0.
  - Else if eng_ok: eng_gnt=1.
  - Never both high in the same cycle.
- Handshake:
  - A transfer occurs on the rising edge where req && gnt.
  - The requester drops or changes req/addr only after that edge.
- Issue stage: on a transfer edge, bank_addr, bank_we and bank_wdata register the winner's values.
  - Engine transfers always register bank_we=0.
  - With no transfer, bank_we registers 0 and bank_addr holds its last value.
- Read return pipeline: 2-stage owner tag {valid, owner}.
  - Stage1 is set on a read transfer.
  - Stage2 follows one cycle later. Stage2 valid with owner=CPU drives cpu_rvalid=1; owner=ENG drives eng_rvalid=1.
  - cpu_rdata and eng_rdata are bank_rdata, passed combinationally.
  - Total latency: rvalid is high for exactly one cycle, in the cycle after edge k+1, where k is the transfer edge.
  - Back-to-back reads return in order, one per cycle, at full throughput.
- Writes produce no rvalid. A write commits at the bank on edge k+1. A read issued after a write to the same address returns the new data.
- wait_cnt (4 bits):
  - Increments, saturating at MAX_WAIT, on each edge where eng_ok && !eng_gnt.
  - Clears on an engine transfer or when eng_en=0.
  - eng_stall_cnt = wait_cnt.
- eng_en deasserted:
  - eng_gnt is forced to 0.
  - Engine reads already in the pipeline still complete and assert eng_rvalid.
- CPU starvation bound: after an engine priority win, wait_cnt clears, so the CPU wins the next contended cycle. The CPU waits at most 1 cycle per MAX_WAIT+1 contended cycles.
- Reset mid-operation: pipeline tags clear immediately, no rvalid is emitted for in-flight reads, and bank_we drops.

Test Plan:
- CPU write 0x1234 to 0x00A, then CPU read 0x00A -> cpu_gnt high both cycles; cpu_rvalid with cpu_rdata=0x1234 two cycles after the read handshake; eng_rvalid stays 0.
- Engine-only reads of 0x00A..0x00D on consecutive cycles -> eng_gnt every cycle; eng_rvalid high for 4 consecutive cycles with data in address order; bank_we=0 throughout.
- cpu_req and eng_req both held continuously, MAX_WAIT=4 -> CPU granted 4 cycles, engine granted on the 5th, pattern repeats; eng_stall_cnt counts 1,2,3,4 then 0.
- eng_en dropped one cycle after an engine read handshake, with eng_req held -> no further eng_gnt; the pending read still asserts eng_rvalid once; eng_stall_cnt=0.
- rst pulsed while two reads are in flight -> cpu_rvalid and eng_rvalid never assert for them; all outputs 0 during reset; normal operation on the first edge after release.
- CPU write 0x00FF to 0x010 granted in the same cycle an engine read of 0x010 is pending -> the engine is granted next and receives 0x00FF.

Source files
------------

// File: rtl/bank_access_arbiter.sv
// Arbitrates the single-port data bank between the CPU access path (read/write)
// and the watermark block-fetch engine (read-only), and routes read data back by owner.
module bank_access_arbiter #(
    parameter int AMBA_WORD = 16,
    parameter int ADDR_W    = 21,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [AMBA_WORD-1:0] cpu_wdata,
    output logic                 cpu_gnt,
    output logic                 cpu_rvalid,
    output logic [AMBA_WORD-1:0] cpu_rdata,
    input  logic                 eng_en,
    input  logic                 eng_req,
    input  logic [ADDR_W-1:0]    eng_addr,
    output logic                 eng_gnt,
    output logic                 eng_rvalid,
    output logic [AMBA_WORD-1:0] eng_rdata,
    output logic                 bank_we,
    output logic [ADDR_W-1:0]    bank_addr,
    output logic [AMBA_WORD-1:0] bank_wdata,
    input  logic [AMBA_WORD-1:0] bank_rdata,
    output logic [3:0]           eng_stall_cnt
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_ENG = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    logic                 w_eng_ok;
    logic                 w_cpu_gnt;
    logic                 w_eng_gnt;
    logic                 w_cpu_xfer;
    logic                 w_eng_xfer;
    tag_t                 w_tag_next;

    logic                 r_bank_we;
    logic [ADDR_W-1:0]    r_bank_addr;
    logic [AMBA_WORD-1:0] r_bank_wdata;
    tag_t                 r_tag1;
    tag_t                 r_tag2;
    logic [3:0]           r_wait_cnt;

    // Engine wins only once it has stalled MAX_WAIT times; otherwise the CPU has priority.
    always_comb begin
        w_eng_ok  = eng_req && eng_en;
        w_cpu_gnt = 1'b0;
        w_eng_gnt = 1'b0;
        if (w_eng_ok && (r_wait_cnt == MAX_WAIT_C)) begin
            w_eng_gnt = 1'b1;
        end else if (cpu_req) begin
            w_cpu_gnt = 1'b1;
        end else if (w_eng_ok) begin
            w_eng_gnt = 1'b1;
        end
    end

    always_comb begin
        w_cpu_xfer       = cpu_req && w_cpu_gnt;
        w_eng_xfer       = w_eng_ok && w_eng_gnt;
        w_tag_next.valid = (w_cpu_xfer && !cpu_we) || w_eng_xfer;
        w_tag_next.owner = w_eng_xfer ? OWN_ENG : OWN_CPU;
    end

    // NOTE: tags clear asynchronously, so reads in flight at reset are dropped rather than delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_we    <= 1'b0;
            r_bank_addr  <= '0;
            r_bank_wdata <= '0;
            r_tag1       <= '0;
            r_tag2       <= '0;
        end else begin
            r_tag1 <= w_tag_next;
            r_tag2 <= r_tag1;
            if (w_cpu_xfer) begin
                r_bank_we    <= cpu_we;
                r_bank_addr  <= cpu_addr;
                r_bank_wdata <= cpu_wdata;
            end else if (w_eng_xfer) begin
                r_bank_we    <= 1'b0;
                r_bank_addr  <= eng_addr;
            end else begin
                r_bank_we    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!eng_en || w_eng_xfer) begin
            r_wait_cnt <= '0;
        end else if (w_eng_ok && !w_eng_gnt && (r_wait_cnt < MAX_WAIT_C)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign cpu_gnt       = w_cpu_gnt;
    assign eng_gnt       = w_eng_gnt;
    assign bank_we       = r_bank_we;
    assign bank_addr     = r_bank_addr;
    assign bank_wdata    = r_bank_wdata;
    assign cpu_rvalid    = r_tag2.valid && (r_tag2.owner == OWN_CPU);
    assign eng_rvalid    = r_tag2.valid && (r_tag2.owner == OWN_ENG);
    assign cpu_rdata     = bank_rdata;
    assign eng_rdata     = bank_rdata;
    assign eng_stall_cnt = r_wait_cnt;

endmodule

// File: tb/tb_bank_access_arbiter.sv
// Bench for bank_access_arbiter: per-cycle vector table for grants/stall/bank drive,
// plus a read-data scoreboard fed at issue and drained on rvalid.
module tb_bank_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [20:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        eng_en, eng_req, eng_gnt, eng_rvalid;
    logic [20:0] eng_addr;
    logic [15:0] eng_rdata;
    logic        bank_we;
    logic [20:0] bank_addr;
    logic [15:0] bank_wdata;
    logic [15:0] bank_rdata;
    logic [3:0]  eng_stall_cnt;

    always #5 clk = ~clk;

    bank_access_arbiter #(.AMBA_WORD(16), .ADDR_W(21), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .eng_en(eng_en), .eng_req(eng_req), .eng_addr(eng_addr),
        .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata), .eng_stall_cnt(eng_stall_cnt)
    );

    // Data bank: write and read-out both use the address registered on the previous edge.
    logic [15:0] bank_mem [0:255];
    always @(posedge clk) begin
        if (bank_we) bank_mem[bank_addr[7:0]] <= bank_wdata;
        bank_rdata <= bank_mem[bank_addr[7:0]];
    end

    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [20:0] c_addr;
        logic [15:0] c_wd;
        logic        e_en;
        logic        e_req;
        logic [20:0] e_addr;
        logic        x_cgnt;
        logic        x_egnt;
        logic [3:0]  x_stall;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] ref_mem [0:255];
    logic [15:0] cpu_q[$];
    logic [15:0] eng_q[$];
    logic        exp_bank_we;
    logic [20:0] exp_bank_addr;
    logic [15:0] exp_bank_wdata;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic c_req, input logic c_we, input logic [20:0] c_addr,
                                input logic [15:0] c_wd, input logic e_en, input logic e_req,
                                input logic [20:0] e_addr, input logic x_cgnt, input logic x_egnt,
                                input logic [3:0] x_stall);
        vec_t v;
        v.c_req = c_req; v.c_we = c_we; v.c_addr = c_addr; v.c_wd = c_wd;
        v.e_en = e_en; v.e_req = e_req; v.e_addr = e_addr;
        v.x_cgnt = x_cgnt; v.x_egnt = x_egnt; v.x_stall = x_stall;
        return v;
    endfunction

    function automatic vec_t idle(input logic e_en);
        return mk(0, 0, 0, 0, e_en, 0, 0, 0, 0, 0);
    endfunction

    // One cycle: drive after the edge, check at the falling edge, then record what transfers.
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_wdata = v.c_wd;
        eng_en = v.e_en; eng_req = v.e_req; eng_addr = v.e_addr;
        @(negedge clk);
        check("cpu_gnt", cpu_gnt, v.x_cgnt);
        check("eng_gnt", eng_gnt, v.x_egnt);
        check("eng_stall_cnt", eng_stall_cnt, v.x_stall);
        check("bank_we", bank_we, exp_bank_we);
        check("bank_addr", bank_addr, exp_bank_addr);
        if (exp_bank_we) check("bank_wdata", bank_wdata, exp_bank_wdata);
        exp_bank_we = 1'b0;
        if (v.x_cgnt) begin
            exp_bank_addr = v.c_addr;
            if (v.c_we) begin
                exp_bank_we    = 1'b1;
                exp_bank_wdata = v.c_wd;
                ref_mem[v.c_addr[7:0]] = v.c_wd;
            end else begin
                cpu_q.push_back(ref_mem[v.c_addr[7:0]]);
            end
        end else if (v.x_egnt) begin
            exp_bank_addr = v.e_addr;
            eng_q.push_back(ref_mem[v.e_addr[7:0]]);
        end
    endtask

    // Read-return monitor: every rvalid must match the oldest outstanding read of that owner.
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 1, 0);
            else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
        if (eng_rvalid) begin
            if (eng_q.size() == 0) check("eng_rvalid_unexpected", 1, 0);
            else check("eng_rdata", eng_rdata, eng_q.pop_front());
        end
    end

    task automatic check_drained(input string tag);
        check({tag, "_cpu_pending"}, cpu_q.size(), 0);
        check({tag, "_eng_pending"}, eng_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_cpu;
        int n_eng;
        logic egnt;

        for (int i = 0; i < 256; i++) begin
            bank_mem[i] = 16'h5A00 ^ 16'(i * 257);
            ref_mem[i]  = 16'h5A00 ^ 16'(i * 257);
        end

        // Write then read back; engine burst; sustained contention; eng_en drop; write-then-engine read.
        vecs.push_back(mk(1, 1, 21'h00A, 16'h1234, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 21'h00A, 16'h0000, 0, 0, 0, 1, 0, 0));
        vecs.push_back(idle(0));
        vecs.push_back(idle(0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 1, 21'(21'h00A + i), 0, 1, 0));
        vecs.push_back(idle(1));
        vecs.push_back(idle(1));
        n_cpu = 0;
        n_eng = 0;
        for (int i = 0; i < 10; i++) begin
            egnt = ((i % 5) == 4);
            vecs.push_back(mk(1, 0, 21'(21'h020 + n_cpu), 0, 1, 1, 21'(21'h030 + n_eng),
                              !egnt, egnt, 4'(i % 5)));
            if (egnt) n_eng++;
            else n_cpu++;
        end
        vecs.push_back(mk(1, 0, 21'h02A, 0, 1, 1, 21'h032, 1, 0, 0));
        vecs.push_back(mk(1, 0, 21'h02B, 0, 1, 1, 21'h032, 1, 0, 1));
        vecs.push_back(mk(1, 0, 21'h02C, 0, 0, 1, 21'h032, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 21'h032, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 21'h032, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 21'h033, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 21'h034, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 21'h034, 0, 0, 0));
        vecs.push_back(idle(0));
        vecs.push_back(mk(1, 1, 21'h010, 16'h00FF, 1, 1, 21'h010, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 21'h010, 0, 1, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(idle(0));

        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        eng_en = 0; eng_req = 0; eng_addr = 0;
        exp_bank_we = 1'b0; exp_bank_addr = '0; exp_bank_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_bank_we", bank_we, 0);
        check("rst_bank_addr", bank_addr, 0);
        check("rst_bank_wdata", bank_wdata, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_eng_rvalid", eng_rvalid, 0);
        check("rst_stall", eng_stall_cnt, 0);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);
        check_drained("table");

        // Reset with two CPU reads in flight and a nonzero stall count.
        apply(mk(1, 0, 21'h005, 0, 1, 1, 21'h006, 1, 0, 0));
        apply(mk(1, 0, 21'h007, 0, 1, 1, 21'h006, 1, 0, 1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        eng_en = 0; eng_req = 0; eng_addr = 0;
        cpu_q.delete();
        eng_q.delete();
        exp_bank_we = 1'b0; exp_bank_addr = '0; exp_bank_wdata = '0;
        @(negedge clk);
        check("midrst_cpu_gnt", cpu_gnt, 0);
        check("midrst_eng_gnt", eng_gnt, 0);
        check("midrst_cpu_rvalid", cpu_rvalid, 0);
        check("midrst_eng_rvalid", eng_rvalid, 0);
        check("midrst_bank_we", bank_we, 0);
        check("midrst_bank_addr", bank_addr, 0);
        check("midrst_bank_wdata", bank_wdata, 0);
        check("midrst_stall", eng_stall_cnt, 0);
        @(negedge clk);
        check("midrst_cpu_rvalid_2", cpu_rvalid, 0);
        check("midrst_eng_rvalid_2", eng_rvalid, 0);
        rst = 1'b0;

        apply(mk(1, 0, 21'h008, 0, 1, 1, 21'h009, 1, 0, 0));
        apply(mk(0, 0, 0, 0, 1, 1, 21'h009, 0, 1, 1));
        for (int i = 0; i < 3; i++) apply(idle(0));
        check_drained("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
